// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: funct3 size encodings,
// FSM state enum and the access-width classifier.
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        ACC_B = 2'd0,
        ACC_H = 2'd1,
        ACC_W = 2'd2
    } lsu_acc_e;

    // Undefined size codes fall into the word class
    function automatic lsu_acc_e acc_class(input logic [2:0] size);
        lsu_acc_e c;
        unique case (size)
            LDST_B, LDST_BU: c = ACC_B;
            LDST_H, LDST_HU: c = ACC_H;
            default:         c = ACC_W;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Load-path lane select and sign/zero extension of the memory word.
// Output is forced to zero unless en is set.
module riscv_lsu_load_align
    import lsu_pkg::*;
(
    input  logic        en,
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] rd
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b  = word[{off, 3'b000} +: 8];
        h  = off[1] ? word[31:16] : word[15:0];
        rd = '0;
        if (en) begin
            unique case (size)
                LDST_B:  rd = {{24{b[7]}}, b};
                LDST_BU: rd = {24'b0, b};
                LDST_H:  rd = {{16{h[15]}}, h};
                LDST_HU: rd = {16'b0, h};
                default: rd = word;
            endcase
        end
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: byte-enable/data lane steering, 2-state handshake FSM.
// Optional macro LSU_MISALIGN_TRAP_EN blocks misaligned half/word accesses.
module riscv_lsu
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_e state_q, state_d;
    logic [1:0] off_q;
    logic [2:0] size_q;
    lsu_acc_e   acc;
    logic       trap;
    logic       issue;

    assign acc = acc_class(core_size_i);

`ifdef LSU_MISALIGN_TRAP_EN
    // Held off during reset so outputs mirror the request only
    assign trap = rst_ni
                & (((acc == ACC_H) & core_addr_i[0])
                |  ((acc == ACC_W) & (|core_addr_i[1:0])));
`else
    assign trap = 1'b0;
`endif

    assign mem_addr_o = core_addr_i;
    assign mem_we_o   = core_we_i;

    always_comb begin
        mem_be_o = 4'b1111;
        mem_wd_o = core_wd_i;
        unique case (1'b1)
            (acc == ACC_B): begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            (acc == ACC_H): begin
                mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
        endcase
    end

    always_comb begin
        state_d         = state_q;
        mem_req_o       = 1'b0;
        core_stall_o    = 1'b0;
        core_misalign_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (trap) begin
                        core_misalign_o = 1'b1;
                    end else begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                core_stall_o = ~mem_ready_i;
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue = (state_q == IDLE) & core_req_i & ~trap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            off_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                off_q  <= core_addr_i[1:0];
                size_q <= core_size_i;
            end
        end
    end

    riscv_lsu_load_align u_load_align (
        .en   (state_q == WAIT),
        .word (mem_rd_i),
        .off  (off_q),
        .size (size_q),
        .rd   (core_rd_o)
    );

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu with a byte-array reference memory
// and a registered-read data memory model.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd;
    logic        mem_ready;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] mem [0:255];
    logic [7:0]  ref_mem [0:1023];

    always #5 clk = ~clk;

    riscv_lsu dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .core_req_i      (core_req),
        .core_we_i       (core_we),
        .core_size_i     (core_size),
        .core_addr_i     (core_addr),
        .core_wd_i       (core_wd),
        .core_rd_o       (core_rd_o),
        .core_stall_o    (core_stall_o),
        .core_misalign_o (core_misalign_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wd_o        (mem_wd_o),
        .mem_rd_i        (mem_rd),
        .mem_ready_i     (mem_ready)
    );

    // Data memory: read registered on the request edge, byte-masked write
    always @(posedge clk) begin
        if (mem_req_o) begin
            mem_rd <= mem[mem_addr_o[9:2]];
            if (mem_we_o) begin
                for (int k = 0; k < 4; k++) begin
                    if (mem_be_o[k])
                        mem[mem_addr_o[9:2]][8*k +: 8] <= mem_wd_o[8*k +: 8];
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    task automatic flag(input string n);
        checks++;
        failures++;
        $display("FAIL %s", n);
    endtask

    // 0 = byte, 1 = half, 2 = word
    function automatic int cls(input logic [2:0] s);
        if (s == 3'd0 || s == 3'd4) return 0;
        if (s == 3'd1 || s == 3'd5) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input logic [2:0] s);
        logic [9:0]  x;
        logic [9:0]  hb;
        logic [9:0]  wb;
        logic [15:0] hv;
        x  = a[9:0];
        hb = {x[9:1], 1'b0};
        wb = {x[9:2], 2'b00};
        hv = {ref_mem[hb + 10'd1], ref_mem[hb]};
        case (s)
            3'd0: return {{24{ref_mem[x][7]}}, ref_mem[x]};
            3'd4: return {24'd0, ref_mem[x]};
            3'd1: return {{16{hv[15]}}, hv};
            3'd5: return {16'd0, hv};
            default: return {ref_mem[wb + 10'd3], ref_mem[wb + 10'd2],
                             ref_mem[wb + 10'd1], ref_mem[wb]};
        endcase
    endfunction

    function automatic exp_t make_exp(input logic we, input logic [2:0] s,
                                      input logic [31:0] a,
                                      input logic [31:0] wd, input int nr);
        exp_t e;
        int   c;
        c        = cls(s);
        e.we     = we;
        e.addr   = a;
        e.mis    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        e.mis    = (c == 1 && a[0]) || (c == 2 && a[1:0] != 2'b00);
`endif
        e.stalls = e.mis ? 0 : 1 + nr;
        if (c == 0) begin
            e.be = 4'(1 << (a % 4));
            e.wd = {4{wd[7:0]}};
        end else if (c == 1) begin
            e.be = (a % 4 >= 2) ? 4'hC : 4'h3;
            e.wd = {2{wd[15:0]}};
        end else begin
            e.be = 4'hF;
            e.wd = wd;
        end
        e.rd = e.mis ? 32'd0 : ref_load(a, s);
        return e;
    endfunction

    task automatic ref_store(input exp_t e, input logic [2:0] s);
        logic [9:0] base;
        int         c;
        c    = cls(s);
        base = (c == 0) ? e.addr[9:0]
             : (c == 1) ? {e.addr[9:1], 1'b0} : {e.addr[9:2], 2'b00};
        for (int k = 0; k < 4; k++) begin
            if ((c == 0 && k == 0) || (c == 1 && k < 2) || c == 2)
                ref_mem[base + 10'(k)] = e.wd[8*k +: 8];
        end
    endtask

    task automatic do_access(input logic we, input logic [2:0] s,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int nr);
        exp_t e;
        e = make_exp(we, s, a, wd, nr);
        if (we && !e.mis) ref_store(e, s);
        exp_q.push_back(e);
        @(posedge clk); #1;
        core_req  = 1'b1;
        core_we   = we;
        core_size = s;
        core_addr = a;
        core_wd   = wd;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        if (!e.mis) begin
            for (int k = 0; k < nr; k++) begin
                mem_ready = 1'b0;
                @(posedge clk); #1;
            end
            mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        core_req = 1'b0;
    endtask

    // Monitor: checks issue cycle, stall length and completion data
    int cyc = 0;
    bit busy = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_ni) begin
            busy = 0;
            cyc  = 0;
        end else if (core_req) begin
            if (mem_req_o) begin
                if (busy) begin
                    flag("mem_req_in_wait");
                end else if (exp_q.size() == 0) begin
                    flag("unexpected_issue");
                end else begin
                    e = exp_q[0];
                    chk("issue_expected", 32'(e.mis), 32'(core_misalign_o));
                    chk("mem_addr", mem_addr_o, e.addr);
                    chk("mem_we", 32'(mem_we_o), 32'(e.we));
                    chk("mem_be", 32'(mem_be_o), 32'(e.be));
                    if (e.we) chk("mem_wd", mem_wd_o, e.wd);
                    busy = 1;
                    cyc  = 1;
                end
            end else if (core_stall_o) begin
                if (!busy) flag("stall_without_issue");
                cyc++;
            end else begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    chk("misalign", 32'(core_misalign_o), 32'(e.mis));
                    chk("stall_cycles", 32'(cyc), 32'(e.stalls));
                    if (!e.we) chk("load_rd", core_rd_o, e.rd);
                end
                busy = 0;
                cyc  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  sizes [8];
        logic [31:0] w;
        sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end
        rst_ni    = 1'b0;
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = 3'd2;
        core_addr = 32'h0;
        core_wd   = 32'h0;
        mem_ready = 1'b1;
        #3;
        chk("rst_rd", core_rd_o, 32'd0);
        chk("rst_misalign", 32'(core_misalign_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd1);
        chk("rst_stall", 32'(core_stall_o), 32'd1);
        core_req = 1'b0;
        #1;
        chk("rst_mem_req_lo", 32'(mem_req_o), 32'd0);
        chk("rst_stall_lo", 32'(core_stall_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        do_access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        do_access(1'b0, 3'd2, 32'h10, 32'h0, 0);
        do_access(1'b1, 3'd0, 32'h13, 32'h000000A5, 0);
        do_access(1'b0, 3'd0, 32'h13, 32'h0, 0);
        do_access(1'b0, 3'd4, 32'h13, 32'h0, 0);
        do_access(1'b1, 3'd1, 32'h22, 32'h00008001, 0);
        do_access(1'b0, 3'd1, 32'h22, 32'h0, 0);
        do_access(1'b0, 3'd5, 32'h22, 32'h0, 0);
        do_access(1'b0, 3'd2, 32'h10, 32'h0, 3);

        // Reset pulse while waiting abandons the load
        exp_q.push_back(make_exp(1'b0, 3'd2, 32'h20, 32'h0, 0));
        @(posedge clk); #1;
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = 3'd2;
        core_addr = 32'h20;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        chk("wait_rst_rd", core_rd_o, 32'd0);
        chk("wait_rst_stall", 32'(core_stall_o), 32'd1);
        chk("wait_rst_mem_req", 32'(mem_req_o), 32'd1);
        core_req = 1'b0;
        #1;
        chk("wait_rst_idle_stall", 32'(core_stall_o), 32'd0);
        @(negedge clk);
        void'(exp_q.pop_front());
        #2 rst_ni = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rd", core_rd_o, 32'd0);
        chk("post_rst_stall", 32'(core_stall_o), 32'd0);
        do_access(1'b0, 3'd2, 32'h20, 32'h0, 0);

        do_access(1'b0, 3'd2, 32'h11, 32'h0, 0);

        for (int i = 0; i < 60; i++) begin
            do_access(1'($urandom_range(0, 1)), sizes[$urandom_range(0, 7)],
                      32'($urandom_range(0, 1023)), $urandom,
                      $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
